// File: rtl/xdma_cfg_frame_deserializer.sv
// Assembles one cfg record from a first frame plus continuation frames; XDMA_CFG_DESER_TIMEOUT_EN adds an idle watchdog.
// Record is valid the cycle after the last beat; in_ready_o drops only while a record waits for cfg_ready_i.
module xdma_cfg_frame_deserializer #(
  parameter  int unsigned MaxFrames     = 4,
`ifdef XDMA_CFG_DESER_TIMEOUT_EN
  parameter  int unsigned TimeoutCycles = 1024,
`endif
  localparam int unsigned AxiDataWidth  = 512,
  localparam int unsigned AddrWidth     = 48,
  localparam int unsigned DMAIdWidth    = 4,
  localparam int unsigned PayloadWidth  = 407 + (MaxFrames - 1) * 507
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [AxiDataWidth-1:0] in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [DMAIdWidth-1:0]   cfg_dma_id_o,
  output logic                    cfg_dma_type_o,
  output logic [AddrWidth-1:0]    cfg_reader_addr_o,
  output logic [AddrWidth-1:0]    cfg_writer_addr_o,
  output logic [3:0]              cfg_frame_length_o,
  output logic [PayloadWidth-1:0] cfg_payload_o,
  output logic                    cfg_valid_o,
  input  logic                    cfg_ready_i,
  output logic                    err_o,
  output logic [1:0]              err_code_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [DMAIdWidth-1:0]   id_q, id_d;
  logic                    type_q, type_d;
  logic [AddrWidth-1:0]    raddr_q, raddr_d;
  logic [AddrWidth-1:0]    waddr_q, waddr_d;
  logic [3:0]              len_q, len_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [3:0]              drain_q, drain_d;
  logic [PayloadWidth-1:0] payload_q, payload_d;
  logic                    err_q, err_d;
  logic [1:0]              err_code_q, err_code_d;
  logic                    accept;
  logic [3:0]              in_len;
  logic                    wdog_fire;

  assign accept = in_valid_i & in_ready_o;
  assign in_len = in_data_i[4:1];

`ifdef XDMA_CFG_DESER_TIMEOUT_EN
  localparam int unsigned WdogWidth = $clog2(TimeoutCycles + 1);
  logic [WdogWidth-1:0] wdog_q, wdog_d;

  // Counts idle cycles while a record is open; any accepted beat restarts it.
  always_comb begin
    wdog_d    = '0;
    wdog_fire = 1'b0;
    if ((state_q == COLLECT || state_q == DRAIN) && !accept) begin
      if (wdog_q == WdogWidth'(TimeoutCycles - 1)) wdog_fire = 1'b1;
      else                                         wdog_d    = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_len == 4'd1)                                     state_d = EMIT;
          else if (in_len != 4'd0 && in_len <= 4'(MaxFrames))     state_d = COLLECT;
          else if (in_len > 4'd1)                                 state_d = DRAIN;
        end
      end
      COLLECT: begin
        if (wdog_fire)                                  state_d = IDLE;
        else if (accept && (cnt_q + 4'd1) == len_q)     state_d = EMIT;
      end
      EMIT:    if (cfg_ready_i)                         state_d = IDLE;
      DRAIN: begin
        if (wdog_fire)                                  state_d = IDLE;
        else if (accept && drain_q == 4'd1)             state_d = IDLE;
      end
      default:                                          state_d = IDLE;
    endcase
  end

  always_comb begin
    id_d       = id_q;
    type_d     = type_q;
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    payload_d  = payload_q;
    err_d      = 1'b0;
    err_code_d = 2'd0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          type_d              = in_data_i[0];
          len_d               = in_len;
          id_d                = in_data_i[8:5];
          raddr_d             = in_data_i[56:9];
          waddr_d             = in_data_i[104:57];
          payload_d           = '0;
          payload_d[406:0]    = in_data_i[511:105];
          cnt_d               = 4'd1;
          if (in_len == 4'd0 || in_len > 4'(MaxFrames)) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
            drain_d    = (in_len == 4'd0) ? 4'd0 : in_len - 4'd1;
          end
        end
      end
      COLLECT: begin
        if (wdog_fire) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          payload_d  = '0;
          cnt_d      = 4'd0;
        end else if (accept) begin
          // A mismatched continuation is flagged but still assembled into the record.
          if (in_data_i[3:0] != id_q || in_data_i[4] != type_q) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end
          for (int k = 1; k < int'(MaxFrames); k++) begin
            if (cnt_q == 4'(k)) payload_d[407 + (k - 1) * 507 +: 507] = in_data_i[511:5];
          end
          cnt_d = cnt_q + 4'd1;
        end
      end
      DRAIN: begin
        if (wdog_fire) begin
          err_d      = 1'b1;
          err_code_d = 2'd3;
          drain_d    = 4'd0;
        end else if (accept) begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q       <= '0;
      type_q     <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      drain_q    <= '0;
      payload_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      id_q       <= id_d;
      type_q     <= type_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      payload_q  <= payload_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    in_ready_o  = (state_q != EMIT);
    cfg_valid_o = (state_q == EMIT);
    busy_o      = (state_q != IDLE);
  end

  assign cfg_dma_id_o       = id_q;
  assign cfg_dma_type_o     = type_q;
  assign cfg_reader_addr_o  = raddr_q;
  assign cfg_writer_addr_o  = waddr_q;
  assign cfg_frame_length_o = len_q;
  assign cfg_payload_o      = payload_q;
  assign err_o              = err_q;
  assign err_code_o         = err_code_q;

endmodule
